mmio_uart_tx: RTL

Memory-mapped UART transmitter on the processor data-memory port, downstream of the core alongside data RAM. It decodes `address_to_mem` against a base address and accepts byte stores into a transmit FIFO. It serializes bytes as 8N1 frames on `tx` and returns status on reads. The top level uses `sel` to steer `rd_data` onto the core's `data_from_mem` in place of RAM.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/byte_fifo.sv | 76 +++++++
 rtl/mmio_uart_tx.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
package uart_pkg;

    // Transmit serializer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // Register offsets, in 32-bit words (address_to_mem[3:2])
    localparam logic [1:0] TXDATA_OFS = 2'd0;
    localparam logic [1:0] STATUS_OFS = 2'd1;

    // STATUS bit positions
    localparam int STAT_FULL_BIT  = 0;
    localparam int STAT_EMPTY_BIT = 1;
    localparam int STAT_BUSY_BIT  = 2;
    localparam int STAT_OVF_BIT   = 3;
    localparam int STAT_CNT_LSB   = 8;
    localparam int STAT_CNT_W     = 5;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with occupancy count. A push into a full FIFO is
// accepted only when a pop frees an entry in the same cycle.
module byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [7:0]               push_data_i,
    input  logic                     pop_i,
    output logic [7:0]               pop_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push_s;
    logic          do_pop_s;

    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == {CW{1'b0}});
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rptr_q];

    // Qualify push/pop against occupancy and compute next pointers/count
    always_comb begin
        do_pop_s  = pop_i & ~empty_o;
        do_push_s = push_i & (~full_o | do_pop_s);
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        if (do_push_s) begin
            wptr_d = wptr_q + 1'b1;
        end else begin
            wptr_d = wptr_q;
        end
        if (do_pop_s) begin
            rptr_d = rptr_q + 1'b1;
        end else begin
            rptr_d = rptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wptr_q] <= push_data_i;
        end
    end

    // Pointer and count registers; reset discards all entries
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= {AW{1'b0}};
            rptr_q  <= {AW{1'b0}};
            count_q <= {CW{1'b0}};
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: address decode, TX FIFO, serializer
// FSM and combinational STATUS read path.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        WE,
    input  logic [31:0] address_to_mem,
    input  logic [31:0] data_to_mem,
    output logic        sel,
    output logic [31:0] rd_data,
    output logic        tx
);

    localparam int                BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0]     BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 1;

    tx_state_e          state_q, state_d;
    logic [BW-1:0]      baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;
    logic               ovf_q, ovf_d;

    logic [1:0]         offset_s;
    logic               push_s, pop_s, ovf_clr_s;
    logic [7:0]         fifo_data_s;
    logic               fifo_full_s, fifo_empty_s;
    logic [CNT_W-1:0]   fifo_count_s;
    logic [STAT_CNT_W-1:0] status_cnt_s;
    logic [31:0]        status_s;
    logic               unused_s;

    assign sel       = (address_to_mem[31:4] == BASE_ADDR[31:4]);
    assign offset_s  = address_to_mem[3:2];
    assign push_s    = WE & sel & (offset_s == TXDATA_OFS);
    assign ovf_clr_s = WE & sel & (offset_s == STATUS_OFS) & data_to_mem[3];
    assign tx        = tx_q;
    assign unused_s  = ^{data_to_mem[31:8], address_to_mem[1:0]};

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (reset),
        .push_i      (push_s),
        .push_data_i (data_to_mem[7:0]),
        .pop_i       (pop_s),
        .pop_data_o  (fifo_data_s),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s),
        .count_o     (fifo_count_s)
    );

    // Serializer next-state: baud/bit counters restart on every state entry
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                baud_d = {BW{1'b0}};
                bit_d  = 3'd0;
                if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    shift_d = fifo_data_s;
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = {BW{1'b0}};
                    bit_d   = 3'd0;
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = {BW{1'b0}};
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        bit_d   = 3'd0;
                        state_d = ST_STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = {BW{1'b0}};
                    bit_d  = 3'd0;
                    if (!fifo_empty_s) begin
                        pop_s   = 1'b1;
                        shift_d = fifo_data_s;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                baud_d  = {BW{1'b0}};
                bit_d   = 3'd0;
            end
        endcase
    end

    // Line level for the upcoming state, registered so tx never glitches
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    // Sticky overflow: set by a dropped push, cleared by a STATUS write
    always_comb begin
        ovf_d = ovf_q;
        if (push_s && fifo_full_s && !pop_s) begin
            ovf_d = 1'b1;
        end else if (ovf_clr_s) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Serializer and status registers; reset forces the line idle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            baud_q  <= {BW{1'b0}};
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
        end
    end

    // Combinational read path from registered state
    always_comb begin
        status_cnt_s = {STAT_CNT_W{1'b0}};
        status_cnt_s[CNT_W-1:0] = fifo_count_s;
        status_s = 32'd0;
        status_s[STAT_FULL_BIT]  = fifo_full_s;
        status_s[STAT_EMPTY_BIT] = fifo_empty_s;
        status_s[STAT_BUSY_BIT]  = (state_q != ST_IDLE);
        status_s[STAT_OVF_BIT]   = ovf_q;
        status_s[STAT_CNT_LSB +: STAT_CNT_W] = status_cnt_s;
        rd_data = 32'd0;
        if (sel) begin
            case (offset_s)
                STATUS_OFS: rd_data = status_s;
                default:    rd_data = 32'd0;
            endcase
        end else begin
            rd_data = 32'd0;
        end
    end

endmodule
